// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared types and helpers for the PSRAM transfer scheduler
package psram_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPLIT,
    S_ISSUE,
    S_WAIT,
    S_CMPL
  } sched_state_e;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_LEN_W  = 8;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
    logic                  rdwr;
    logic                  first;
    logic                  last;
  } xfer_cmd_t;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/psram_rr_arb.sv
// rtl/psram_rr_arb.sv - round-robin / fixed-priority channel arbiter
module psram_rr_arb
  import psram_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              upd_en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] cidx;
  logic            found;
  int              cand;

  // Search begins one past the last winner so every channel gets a turn.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (ARB_MODE == ARB_FIXED) ? i : (int'(ptr) + 1 + i) % NUM_CH;
      cidx = CH_W'(cand);
      if (!found && req[cidx]) begin
        found   = 1'b1;
        gnt     = NUM_CH'(1) << cidx;
        gnt_idx = cidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CH_W'(NUM_CH - 1);
    end else if (upd_en && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/psram_xfer_sched.sv
// rtl/psram_xfer_sched.sv - arbitrates request channels and splits bursts into page/tCEM-safe core transfers
module psram_xfer_sched
  import psram_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int PAGE_SIZE  = 1024,
  parameter int ARB_MODE   = ARB_RR,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_en_i,
  input  logic [LEN_WIDTH-1:0]         cfg_max_beats_i,
  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  req_len_i,
  input  logic [NUM_CH-1:0]            req_rdwr_i,
  output logic [NUM_CH-1:0]            cmpl_o,
  output logic                         busy_o,
  output logic [CH_W-1:0]              gnt_id_o,
  output logic                         xfer_valid_o,
  input  logic                         xfer_ready_i,
  output logic [ADDR_WIDTH-1:0]        xfer_addr_o,
  output logic [LEN_WIDTH-1:0]         xfer_len_o,
  output logic                         xfer_rdwr_o,
  output logic                         xfer_first_o,
  output logic                         xfer_last_o,
  input  logic                         xfer_done_i
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BB_W       = $clog2(BEAT_BYTES);
  localparam int PAGE_W     = $clog2(PAGE_SIZE);
  localparam int REM_W      = LEN_WIDTH + 1;

  sched_state_e          state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REM_W-1:0]      rem_q;
  logic [REM_W-1:0]      sub_q;
  logic [REM_W-1:0]      sub_c;
  logic [REM_W-1:0]      rem_left;
  logic                  rdwr_q;
  logic                  first_q;
  logic                  accept;
  logic [NUM_CH-1:0]     gnt;
  logic [CH_W-1:0]       gnt_idx;
  logic [NUM_CH-1:0]     gnt_onehot;
  int unsigned           page_off;
  int unsigned           pg_beats;
  int unsigned           sub_u;

  logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
  logic [LEN_WIDTH-1:0]  ch_len  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_addr[c] = req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign ch_len[c]  = req_len_i[c*LEN_WIDTH +: LEN_WIDTH];
  end

  psram_rr_arb #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .req     (req_valid_i),
    .upd_en  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept      = (state == S_IDLE) && cfg_en_i && (|req_valid_i);
  assign req_ready_o = accept ? gnt : '0;
  assign busy_o      = (state != S_IDLE);
  assign gnt_onehot  = NUM_CH'(1) << gnt_id_o;
  assign rem_left    = rem_q - sub_q;

  // Beats left before the page edge; rem and cap can only shrink it further.
  always_comb begin
    page_off = 32'(addr_q[PAGE_W-1:0]);
    pg_beats = (PAGE_SIZE - page_off) / BEAT_BYTES;
    sub_u    = umin(32'(rem_q), pg_beats);
    if (cfg_max_beats_i != '0) begin
      sub_u = umin(sub_u, 32'(cfg_max_beats_i));
    end
    sub_c = REM_W'(sub_u);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      sub_q        <= '0;
      rdwr_q       <= 1'b0;
      first_q      <= 1'b0;
      gnt_id_o     <= '0;
      cmpl_o       <= '0;
      xfer_valid_o <= 1'b0;
      xfer_addr_o  <= '0;
      xfer_len_o   <= '0;
      xfer_rdwr_o  <= 1'b0;
      xfer_first_o <= 1'b0;
      xfer_last_o  <= 1'b0;
    end else begin
      cmpl_o <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= ch_addr[gnt_idx] & ~ADDR_WIDTH'(BEAT_BYTES - 1);
            rem_q    <= REM_W'(ch_len[gnt_idx]) + REM_W'(1);
            rdwr_q   <= req_rdwr_i[gnt_idx];
            gnt_id_o <= gnt_idx;
            first_q  <= 1'b1;
            state    <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          xfer_addr_o  <= addr_q;
          xfer_len_o   <= LEN_WIDTH'(sub_c - REM_W'(1));
          xfer_rdwr_o  <= rdwr_q;
          xfer_first_o <= first_q;
          xfer_last_o  <= (sub_c == rem_q);
          xfer_valid_o <= 1'b1;
          sub_q        <= sub_c;
          state        <= S_ISSUE;
        end
        S_ISSUE: begin
          if (xfer_ready_i) begin
            xfer_valid_o <= 1'b0;
            addr_q       <= addr_q + (ADDR_WIDTH'(sub_q) << BB_W);
            rem_q        <= rem_left;
            first_q      <= 1'b0;
            if (!xfer_done_i) begin
              state <= S_WAIT;
            end else if (rem_left != '0) begin
              state <= S_SPLIT;
            end else begin
              state  <= S_CMPL;
              cmpl_o <= gnt_onehot;
            end
          end
        end
        S_WAIT: begin
          if (xfer_done_i) begin
            if (rem_q != '0) begin
              state <= S_SPLIT;
            end else begin
              state  <= S_CMPL;
              cmpl_o <= gnt_onehot;
            end
          end
        end
        S_CMPL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
